// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the MMIO UART transmitter: default word addresses,
// STATUS bit map and serialiser state encodings.
package mmio_uart_tx_pkg;

  localparam logic [11:0] TXDATA_ADDR_DEF = 12'hFFE;
  localparam logic [11:0] STATUS_ADDR_DEF = 12'hFFF;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_e;

  function automatic logic [3:0] status_bits(
    input logic ovf,
    input logic busy,
    input logic empty,
    input logic full
  );
    logic [3:0] s;
    s = '0;
    s[STAT_FULL]  = full;
    s[STAT_EMPTY] = empty;
    s[STAT_BUSY]  = busy;
    s[STAT_OVF]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers and first-word-through dout.
// A push while full is accepted only if a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     sysclk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge sysclk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: TXDATA/STATUS decode, status readback, serialiser.
// Define UART_TX_PARITY_EN for 8E1 frames; default build sends 8N1.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 868,
  parameter logic [ADDR_WIDTH-1:0] TXDATA_ADDR = ADDR_WIDTH'(TXDATA_ADDR_DEF),
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(STATUS_ADDR_DEF)
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [3:0]            byte_w_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  sel_rd,
  output logic                  tx,
  output logic                  irq_empty
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_e       state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            ovf_q, ovf_d;
  logic            push_req, pop, clr_req, ovf_set, bit_end;
  logic [7:0]      fifo_dout;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count, count_d;
  logic            unused_ok;

  assign unused_ok = ^{wr_data[DATA_WIDTH-1:8], byte_w_en[3:1]};

  assign push_req = (wr_addr == TXDATA_ADDR) && byte_w_en[0];
  assign clr_req  = (wr_addr == STATUS_ADDR) && byte_w_en[0] && wr_data[3];
  assign pop      = (state_q == S_IDLE) && !fifo_empty;
  assign ovf_set  = push_req && fifo_full && !pop;
  assign ovf_d    = (ovf_q && !clr_req) || ovf_set;
  assign count_d  = fifo_count + CW'(push_req && !ovf_set) - CW'(pop);
  assign bit_end  = (baud_q == BAUD_LAST);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sysclk (sysclk),
    .rst    (rst),
    .push   (push_req),
    .pop    (pop),
    .din    (wr_data[7:0]),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (state_q != S_IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d = fifo_dout;
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_d = bit_q + 1'b1;
`ifdef UART_TX_PARITY_EN
          if (bit_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tx is registered from the next state so the line changes on the edge
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[bit_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = ^shift_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      rd_data <= '0;
      sel_rd  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      sel_rd  <= (rd_addr == STATUS_ADDR);
      if (rd_addr == STATUS_ADDR)
        rd_data <= DATA_WIDTH'(status_bits(
          ovf_d, state_d != S_IDLE,
          count_d == '0, count_d == CW'(FIFO_DEPTH)));
      else
        rd_data <= '0;
    end
  end

  assign tx        = tx_q;
  assign irq_empty = fifo_empty && (state_q == S_IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: pushed bytes are queued, tx frames
// are decoded cycle by cycle and compared; STATUS reads use a second queue.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam logic [11:0] TXD = 12'hFFE;
  localparam logic [11:0] STA = 12'hFFF;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic        sysclk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] wr_addr = 12'h000;
  logic [31:0] wr_data = 32'h0;
  logic [3:0]  byte_w_en = 4'b0000;
  logic [11:0] rd_addr = 12'h010;
  logic [31:0] rd_data;
  logic        sel_rd;
  logic        tx;
  logic        irq_empty;

  mmio_uart_tx #(
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .byte_w_en (byte_w_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .sel_rd    (sel_rd),
    .tx        (tx),
    .irq_empty (irq_empty)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames_done = 0;
  int want_frames = 0;
  int exp_start = -1;
  int last_start = -1;
  int push_cyc = 0;
  bit gap_chk = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    int          due;
    logic        sel;
    logic [31:0] data;
  } rd_exp_t;
  rd_exp_t rd_q[$];

  initial forever begin
    @(posedge sysclk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h (cycle %0d)",
               name, got, want, cyc);
    end
  endtask

  // Frame monitor: one comparison per bit, every cycle of the bit sampled.
  initial begin : tx_mon
    int bidx;
    int cnt;
    bit ok;
    logic [NB-1:0] lv;
    logic [7:0] b;
    bidx = -1;
    cnt = 0;
    ok = 1'b1;
    lv = '1;
    forever begin
      @(negedge sysclk);
      if (rst) begin
        bidx = -1;
      end else if (bidx < 0) begin
        if (tx == 1'b0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected got start bit want idle (cycle %0d)", cyc);
            b = 8'h00;
          end else begin
            b = exp_q.pop_front();
          end
          lv = '1;
          lv[0] = 1'b0;
          lv[8:1] = b;
`ifdef UART_TX_PARITY_EN
          lv[9] = ^b;
`endif
          if (exp_start >= 0) begin
            chk("start_cycle", cyc, exp_start);
            exp_start = -1;
          end
          if (gap_chk && last_start >= 0) begin
            checks++;
            if (cyc - last_start < FRAME || cyc - last_start > FRAME + 1) begin
              errors++;
              $display("FAIL frame_spacing got %0d want %0d..%0d",
                       cyc - last_start, FRAME, FRAME + 1);
            end
          end
          last_start = cyc;
          bidx = 0;
          cnt = 1;
          ok = 1'b1;
        end
      end else begin
        if (tx !== lv[bidx]) ok = 1'b0;
        cnt++;
        if (cnt == CPB) begin
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL frame_bit%0d byte 0x%02h got %0b want %0b",
                     bidx, lv[8:1], tx, lv[bidx]);
          end
          if (bidx == NB - 1) begin
            chk("busy_in_stop", {31'b0, irq_empty}, 32'h0);
            frames_done++;
            bidx = -1;
          end else begin
            bidx++;
          end
          cnt = 0;
          ok = 1'b1;
        end
      end
    end
  end

  initial begin : rd_mon
    rd_exp_t e;
    forever begin
      @(negedge sysclk);
      while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        e = rd_q.pop_front();
        if (e.due < cyc) begin
          checks++;
          errors++;
          $display("FAIL rd_missed got none want due %0d", e.due);
        end else begin
          chk("sel_rd", {31'b0, sel_rd}, {31'b0, e.sel});
          chk("rd_data", rd_data, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic store(input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    wr_addr = a;
    wr_data = d;
    byte_w_en = be;
    push_cyc = cyc;
    tick();
    byte_w_en = 4'b0000;
    wr_addr = 12'h000;
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic [31:0] d;
    d = $urandom();
    d[7:0] = b;
    exp_q.push_back(b);
    want_frames++;
    store(TXD, d, 4'b0001 | 4'($urandom_range(0, 15)));
  endtask

  task automatic read(input logic [11:0] a, input logic s,
                      input logic [31:0] d);
    rd_addr = a;
    rd_q.push_back('{cyc + 1, s, d});
    tick();
    rd_addr = 12'h010;
    rd_q.push_back('{cyc + 1, 1'b0, 32'h0});
    tick();
  endtask

  task automatic wait_frames(input int budget);
    int i;
    i = 0;
    while (frames_done < want_frames && i < budget) begin
      @(posedge sysclk);
      i++;
    end
    #1;
    chk("frames_done", frames_done, want_frames);
  endtask

  task automatic idle_check();
    @(negedge sysclk);
    chk("irq_empty_after", {31'b0, irq_empty}, 32'h1);
    chk("tx_idle_after", {31'b0, tx}, 32'h1);
    tick();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] b;
    logic [3:0] be;
    int n;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge sysclk);
    chk("rst_tx", {31'b0, tx}, 32'h1);
    chk("rst_sel_rd", {31'b0, sel_rd}, 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_irq_empty", {31'b0, irq_empty}, 32'h1);
    tick();

    exp_start = cyc + 2;
    push_byte(8'h55);
    wait_frames(FRAME + 20);
    idle_check();

    gap_chk = 1'b1;
    last_start = -1;
    push_byte(8'hA5);
    push_byte(8'h3C);
    wait_frames(2 * FRAME + 20);
    gap_chk = 1'b0;
    idle_check();

    gap_chk = 1'b1;
    last_start = -1;
    exp_start = cyc + 2;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom());
      if (i < 5) push_byte(b);
      else store(TXD, {24'h0, b}, 4'b0001);
    end
    read(STA, 1'b1, 32'hD);
    store(STA, 32'hFFFF_FFF7, 4'b1111);
    read(STA, 1'b1, 32'hD);
    store(STA, 32'h0000_0008, 4'b0001);
    read(STA, 1'b1, 32'h5);
    wait_frames(5 * FRAME + 40);
    gap_chk = 1'b0;
    read(STA, 1'b1, 32'h2);
    idle_check();

    read(12'h010, 1'b0, 32'h0);
    read(TXD, 1'b0, 32'h0);

    push_byte(8'h96);
    while (cyc < push_cyc + 19) tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    want_frames = frames_done;
    @(negedge sysclk);
    chk("rst_mid_tx", {31'b0, tx}, 32'h1);
    tick();
    read(STA, 1'b1, 32'h2);
    exp_start = cyc + 2;
    push_byte(8'h5A);
    wait_frames(FRAME + 20);
    idle_check();

    exp_start = cyc + 2;
    push_byte(8'h07);
    wait_frames(FRAME + 20);
    idle_check();

    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, DEPTH);
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        if ($urandom_range(0, 3) == 0) begin
          be = {3'($urandom_range(0, 7)), 1'b0};
          if ($urandom_range(0, 1) == 0)
            store(TXD, $urandom(), be);
          else
            store(12'($urandom_range(0, 12'hFFD)), $urandom(), 4'b1111);
        end
        push_byte(8'($urandom()));
      end
      wait_frames((n + 1) * (FRAME + 2) + 20);
    end
    idle_check();

    chk("scoreboard_empty", exp_q.size(), 32'h0);
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
